fft_stage_addr_gen: RTL and testbench
=====================================

Name: fft_stage_addr_gen

Overview:
- Runtime-sized FFT stage sequencer: successor to the fixed halving `fft_size` walk, generalised to any power-of-two size up to 2^MAX_LOG2N.
- For a radix-2 decimation-in-frequency FFT, walks every stage and every butterfly. Emits one butterfly per handshake: operand addresses A/B, twiddle index, stage number, half-span.
- Sits between the FFT top-level controller and the data-memory/twiddle-ROM read ports.

Parameters:
- MAX_LOG2N, 6, log2 of largest supported FFT size; address width = MAX_LOG2N.
- LOG2_W, 3, width of log2n/stage fields; must satisfy 2^LOG2_W > MAX_LOG2N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- log2n  in  LOG2_W  log2 of FFT size; sampled with start.
- abort  in  1  synchronous abort; returns to IDLE, no done.
- out_valid  out  1  butterfly descriptor valid.
- out_ready  in  1  consumer accepts the descriptor when out_valid and out_ready are both high.
- addr_a  out  MAX_LOG2N  upper-leg operand address.
- addr_b  out  MAX_LOG2N  lower-leg operand address (addr_a + half).
- tw_idx  out  MAX_LOG2N-1  twiddle index in units of W_N.
- stage  out  LOG2_W  current stage, 0..log2n-1.
- half  out  MAX_LOG2N  current half-span, N>>(stage+1).
- stage_last  out  1  descriptor is the last butterfly of its stage.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at transform completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0.
- States: IDLE, RUN.
- IDLE: start=1 latches L = log2n.
  - L=0: no RUN; done=1 next cycle.
  - L>MAX_LOG2N: saturates to MAX_LOG2N.
  - Otherwise: next cycle state RUN, busy=1, out_valid=1 with the first descriptor (stage 0, pos 0, group base 0).
- RUN:
  - out_valid stays high continuously.
  - Descriptor fields are held stable while out_valid && !out_ready.
  - Advance happens only on handshake.
- Descriptor generation (no divider):
  - half = N>>(stage+1).
  - pos counter runs 0..half-1.
  - base counter steps by 2*half.
  - addr_a = base+pos; addr_b = base+pos+half; tw_idx = pos<<stage.
- Handshake advance:
  - If pos<half-1: pos++.
  - Else if base+2*half<N: pos=0, base+=2*half.
  - Else (stage end): pos=0, base=0, stage++, half>>=1.
- stage_last = (pos==half-1) && (base+2*half==N).
- Per transform: L stages × N/2 butterflies = L*2^(L-1) handshakes.
- Completion:
  - Handshake on the descriptor with stage==L-1 and stage_last: at that edge state becomes IDLE, out_valid=0, busy=0.
  - done=1 for exactly that following cycle.
  - A start presented during the done cycle is accepted (state is IDLE).
- start in RUN: ignored; no effect on the sequence.
- abort:
  - abort=1 in RUN: next cycle IDLE, out_valid=0, busy=0, done=0.
  - abort beats a simultaneous handshake.
  - abort in IDLE has no effect; abort and start together in IDLE: abort wins, start ignored.
- Reset mid-RUN: immediate IDLE, all outputs 0; no done.
- Widths:
  - base+2*half is computed at MAX_LOG2N+1 bits to avoid wrap at N=2^MAX_LOG2N.
  - tw_idx < N/2 always.

Test Plan:
- Reset, then log2n=3 with out_ready=1: 12 beats, the first cycle after start out_valid=1.
  - Stage 0 (half=4): (0,4,0),(1,5,1),(2,6,2),(3,7,3).
  - Stage 1 (half=2): (0,2,0),(1,3,2),(4,6,0),(5,7,2).
  - Stage 2 (half=1): (0,1,0),(2,3,0),(4,5,0),(6,7,0).
  - stage_last on beats 4, 8, 12; done pulse in the cycle after beat 12.
- Backpressure: log2n=2, out_ready toggled 1,0,0,1,...: fields stable while stalled; the sequence (0,2,0),(1,3,1),(0,1,0),(2,3,0) is unchanged; done after the 4th accept.
- log2n=6 (MAX): 192 accepts; final descriptor stage=5, addr_a=62, addr_b=63, tw_idx=0; no address wrap; single done.
- log2n=0 → done pulse one cycle after start, out_valid never asserted. log2n=7 → behaves as 6 (192 beats).
- abort after beat 5 of log2n=3 → next cycle out_valid=0, busy=0, no done; a new start then restarts at (0,4,0).
- rst_n low mid-RUN for one cycle → all outputs 0 asynchronously; start pulsed in RUN and start pulsed with abort both ignored.

Source files
------------

// File: rtl/fft_stage_addr_gen_if.sv
// Butterfly-descriptor bus between the FFT controller and the stage address generator.
// The master side requests transforms and consumes descriptors; the slave side is the generator.
interface fft_stage_addr_gen_if #(
  parameter int MAX_LOG2N = 6,
  parameter int LOG2_W    = 3
);
  logic                  start;
  logic [LOG2_W-1:0]     log2n;
  logic                  abort;
  logic                  out_valid;
  logic                  out_ready;
  logic [MAX_LOG2N-1:0]  addr_a;
  logic [MAX_LOG2N-1:0]  addr_b;
  logic [MAX_LOG2N-2:0]  tw_idx;
  logic [LOG2_W-1:0]     stage;
  logic [MAX_LOG2N-1:0]  half;
  logic                  stage_last;
  logic                  busy;
  logic                  done;

  modport master (
    output start, log2n, abort, out_ready,
    input  out_valid, addr_a, addr_b, tw_idx, stage, half, stage_last, busy, done
  );

  modport slave (
    input  start, log2n, abort, out_ready,
    output out_valid, addr_a, addr_b, tw_idx, stage, half, stage_last, busy, done
  );
endinterface

// File: rtl/fft_stage_addr_gen.sv
// Radix-2 DIF FFT sequencer: walks stage/group/position for a runtime size 2^L
// and emits one butterfly descriptor (A/B addresses, twiddle index) per handshake.
module fft_stage_addr_gen #(
  parameter int MAX_LOG2N = 6,
  parameter int LOG2_W    = 3
) (
  input logic                clk,
  input logic                rst_n,
  fft_stage_addr_gen_if.slave bus
);
  localparam int AW = MAX_LOG2N;
  localparam int NW = MAX_LOG2N + 1;
  localparam int TW = MAX_LOG2N - 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [LOG2_W-1:0] l_q, l_d;
  logic [LOG2_W-1:0] stage_q, stage_d;
  logic [TW-1:0]     pos_q, pos_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     half_q, half_d;
  logic              done_q, done_d;

  logic              run;
  logic [NW-1:0]     n_full;
  logic [NW-1:0]     base_next;
  logic [AW-1:0]     half_m1;
  logic              pos_end;
  logic              group_end;
  logic              stage_final;
  logic [LOG2_W-1:0] l_sat;
  logic [AW-1:0]     addr_a;

  assign run         = (state_q == RUN);
  // One extra bit so base+2*half == N does not wrap when N = 2^MAX_LOG2N.
  assign n_full      = NW'(1) << l_q;
  assign base_next   = {1'b0, base_q} + {half_q, 1'b0};
  assign half_m1     = half_q - AW'(1);
  assign pos_end     = ({1'b0, pos_q} == half_m1);
  assign group_end   = (base_next == n_full);
  assign stage_final = (stage_q == l_q - LOG2_W'(1));
  assign l_sat       = (bus.log2n > LOG2_W'(MAX_LOG2N)) ? LOG2_W'(MAX_LOG2N) : bus.log2n;

  // NOTE: always_comb starts with a default for every _d signal so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    stage_d = stage_q;
    pos_d   = pos_q;
    base_d  = base_q;
    half_d  = half_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (l_sat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            l_d     = l_sat;
            stage_d = '0;
            pos_d   = '0;
            base_d  = '0;
            half_d  = AW'(1) << (l_sat - LOG2_W'(1));
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          stage_d = '0;
          pos_d   = '0;
          base_d  = '0;
          half_d  = '0;
        end else if (bus.out_ready) begin
          if (!pos_end) begin
            pos_d = pos_q + TW'(1);
          end else if (!group_end) begin
            pos_d  = '0;
            base_d = base_next[AW-1:0];
          end else if (stage_final) begin
            // Counters are cleared on exit so every descriptor field reads 0 in IDLE.
            state_d = IDLE;
            done_d  = 1'b1;
            stage_d = '0;
            pos_d   = '0;
            base_d  = '0;
            half_d  = '0;
          end else begin
            pos_d   = '0;
            base_d  = '0;
            stage_d = stage_q + LOG2_W'(1);
            half_d  = half_q >> 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      l_q     <= '0;
      stage_q <= '0;
      pos_q   <= '0;
      base_q  <= '0;
      half_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      stage_q <= stage_d;
      pos_q   <= pos_d;
      base_q  <= base_d;
      half_q  <= half_d;
      done_q  <= done_d;
    end
  end

  assign addr_a         = base_q + AW'(pos_q);
  assign bus.addr_a     = addr_a;
  assign bus.addr_b     = addr_a + half_q;
  assign bus.tw_idx     = pos_q << stage_q;
  assign bus.stage      = stage_q;
  assign bus.half       = half_q;
  assign bus.stage_last = run && pos_end && group_end;
  assign bus.out_valid  = run;
  assign bus.busy       = run;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_fft_stage_addr_gen.sv
// Randomized bench for fft_stage_addr_gen: descriptors are compared against a
// nested-loop model of the radix-2 DIF butterfly schedule.
module tb_fft_stage_addr_gen;
  localparam int MAX_LOG2N = 6;
  localparam int LOG2_W    = 3;

  typedef struct {
    int a;
    int b;
    int tw;
    int stage;
    int half;
    int last;
  } desc_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  desc_t model_q[$];

  fft_stage_addr_gen_if #(.MAX_LOG2N(MAX_LOG2N), .LOG2_W(LOG2_W)) bus ();

  fft_stage_addr_gen #(.MAX_LOG2N(MAX_LOG2N), .LOG2_W(LOG2_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected schedule: for each stage, each group of 2*half, each position in the group.
  function automatic void build_model(input int l);
    int n;
    int h;
    model_q.delete();
    n = 1 << l;
    for (int s = 0; s < l; s++) begin
      h = n >> (s + 1);
      for (int base = 0; base < n; base += 2 * h) begin
        for (int p = 0; p < h; p++) begin
          model_q.push_back('{base + p, base + p + h, p << s, s, h,
                              ((p == h - 1) && (base + 2 * h == n)) ? 1 : 0});
        end
      end
    end
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_done"},  bus.done, 0);
    check({tag, "_a"},     bus.addr_a, 0);
    check({tag, "_b"},     bus.addr_b, 0);
    check({tag, "_tw"},    bus.tw_idx, 0);
    check({tag, "_stage"}, bus.stage, 0);
    check({tag, "_half"},  bus.half, 0);
    check({tag, "_last"},  bus.stage_last, 0);
  endtask

  // mode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready.
  task automatic run_transform(input int l, input int mode, input int abort_after,
                               input bit pre_started, input int chain_next);
    int  leff;
    int  idx;
    int  cyc;
    bit  rdy;
    leff = (l > MAX_LOG2N) ? MAX_LOG2N : l;
    build_model(leff);
    if (!pre_started) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.log2n = LOG2_W'(l);
    end
    @(negedge clk);
    bus.start = 1'b0;
    if (leff == 0) begin
      check("l0_done", bus.done, 1);
      check("l0_valid", bus.out_valid, 0);
      @(negedge clk);
      check("l0_done_clr", bus.done, 0);
      check("l0_valid_clr", bus.out_valid, 0);
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < model_q.size()) begin
      check("valid", bus.out_valid, 1);
      check("busy",  bus.busy, 1);
      check("done_early", bus.done, 0);
      check("addr_a", bus.addr_a, model_q[idx].a);
      check("addr_b", bus.addr_b, model_q[idx].b);
      check("tw_idx", bus.tw_idx, model_q[idx].tw);
      check("stage",  bus.stage, model_q[idx].stage);
      check("half",   bus.half, model_q[idx].half);
      check("stage_last", bus.stage_last, model_q[idx].last);
      if (abort_after > 0 && idx == abort_after) begin
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy",  bus.busy, 0);
        check("abort_done",  bus.done, 0);
        @(negedge clk);
        check("abort_nodone", bus.done, 0);
        check("abort_idle",   bus.out_valid, 0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      bus.out_ready = rdy;
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.log2n     = LOG2_W'($urandom_range(0, 7));
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
      if (cyc > 5000) begin
        check("timeout_beats", idx, model_q.size());
        break;
      end
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("done_pulse", bus.done, 1);
    check("end_valid",  bus.out_valid, 0);
    check("end_busy",   bus.busy, 0);
    if (chain_next >= 0) begin
      bus.start = 1'b1;
      bus.log2n = LOG2_W'(chain_next);
    end else begin
      @(negedge clk);
      check("done_single", bus.done, 0);
      check("idle_valid",  bus.out_valid, 0);
    end
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    bus.start = 1'b1;
    bus.log2n = LOG2_W'(4);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("prerst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero("rst_async");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("postrst_valid", bus.out_valid, 0);
    check("postrst_done",  bus.done, 0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.log2n     = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("post_reset");

    run_transform(3, 0, 0, 1'b0, -1);
    run_transform(2, 1, 0, 1'b0, -1);
    run_transform(6, 2, 0, 1'b0, -1);
    run_transform(0, 0, 0, 1'b0, -1);
    run_transform(7, 2, 0, 1'b0, -1);
    run_transform(3, 0, 5, 1'b0, -1);
    run_transform(3, 0, 0, 1'b0, -1);

    // start together with abort in IDLE must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.log2n = LOG2_W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_abort_valid", bus.out_valid, 0);
    check("idle_abort_done",  bus.done, 0);

    // start during the done cycle is accepted
    run_transform(1, 0, 0, 1'b0, 2);
    run_transform(2, 2, 0, 1'b1, -1);

    reset_mid_run();

    for (int t = 0; t < 8; t++) begin
      run_transform($urandom_range(0, 7), $urandom_range(0, 2), 0, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
